// File: rtl/alu_mdu_seq_if.sv
// alu_mdu_seq_if: operation request / result handshake bundle for alu_mdu_seq
interface alu_mdu_seq_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [3:0]       alu_ctrl;
    logic             illegal;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, alu_op, funct, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, alu_ctrl, illegal, div_by_zero, hi, lo
    );

    modport slave (
        input  in_valid, alu_op, funct, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, alu_ctrl, illegal, div_by_zero, hi, lo
    );
endinterface

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: ALU decode plus iterative MIPS mult/div unit with HI/LO and valid/ready handshake
module alu_mdu_seq #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    alu_mdu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               div_q, div_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic               ill_q, ill_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [3:0]         fdec, dec;
    logic [WIDTH-1:0]   alu_res;
    logic               is_md, is_div, is_sgn, bz, sa, sb;
    logic [WIDTH-1:0]   ma, mb;
    logic [WIDTH:0]     mul_sum, rs, diff;
    logic [2*WIDTH-1:0] step_p, mprod;
    logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

    always_comb begin
        case (bus.funct)
            6'b100000: fdec = 4'b0010;
            6'b100010: fdec = 4'b0110;
            6'b100100: fdec = 4'b0000;
            6'b100101: fdec = 4'b0001;
            6'b100111: fdec = 4'b1100;
            6'b101010: fdec = 4'b0111;
            6'b011000: fdec = 4'b1000;
            6'b011001: fdec = 4'b1001;
            6'b011010: fdec = 4'b1010;
            6'b011011: fdec = 4'b1011;
            6'b010000: fdec = 4'b1101;
            6'b010010: fdec = 4'b1110;
            default:   fdec = 4'b1111;
        endcase
        dec = bus.alu_op[0] ? 4'b0110 : bus.alu_op[1] ? fdec : 4'b0010;
    end

    always_comb begin
        case (dec)
            4'b0010: alu_res = bus.src_a + bus.src_b;
            4'b0110: alu_res = bus.src_a - bus.src_b;
            4'b0000: alu_res = bus.src_a & bus.src_b;
            4'b0001: alu_res = bus.src_a | bus.src_b;
            4'b1100: alu_res = ~(bus.src_a | bus.src_b);
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
            4'b1101: alu_res = hi_q;
            4'b1110: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // Iteration works on magnitudes; signs are reapplied on the final step.
    assign is_md  = dec[3:2] == 2'b10;
    assign is_div = is_md && dec[1];
    assign is_sgn = !dec[0];
    assign bz     = bus.src_b == '0;
    assign sa     = is_sgn && bus.src_a[WIDTH-1];
    assign sb     = is_sgn && bus.src_b[WIDTH-1];
    assign ma     = sa ? -bus.src_a : bus.src_a;
    assign mb     = sb ? -bus.src_b : bus.src_b;

    always_comb begin
        mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        rs      = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        diff    = rs - {1'b0, m_q};
        step_p  = !div_q ? {mul_sum, p_q[WIDTH-1:1]}
                : diff[WIDTH] ? {rs[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                : {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        mprod   = neg_q ? -step_p : step_p;
        quo     = step_p[WIDTH-1:0];
        rem     = step_p[2*WIDTH-1:WIDTH];
        fin_hi  = div_q ? (rneg_q ? -rem : rem) : mprod[2*WIDTH-1:WIDTH];
        fin_lo  = div_q ? (neg_q ? -quo : quo) : mprod[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        m_d     = m_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div_d   = div_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ctrl_d  = ctrl_q;
        ill_d   = ill_q;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                ctrl_d = dec;
                ill_d  = dec == 4'b1111;
                dbz_d  = is_div && bz;
                div_d  = is_div;
                neg_d  = sa ^ sb;
                rneg_d = sa;
                m_d    = is_div ? mb : ma;
                p_d    = {{WIDTH{1'b0}}, is_div ? ma : mb};
                cnt_d  = CW'(WIDTH);
                if (is_md && !(is_div && bz)) begin
                    state_d = BUSY;
                end else begin
                    state_d = HOLD;
                    res_d   = alu_res;
                    zero_d  = alu_res == '0;
                end
            end
            BUSY: begin
                p_d   = step_p;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = HOLD;
                    hi_d    = fin_hi;
                    lo_d    = fin_lo;
                    res_d   = fin_lo;
                    zero_d  = fin_lo == '0;
                end
            end
            HOLD: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            m_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div_q   <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ctrl_q  <= '0;
            ill_q   <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            m_q     <= m_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div_q   <= div_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ctrl_q  <= ctrl_d;
            ill_q   <= ill_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.in_ready    = state_q == IDLE;
    assign bus.out_valid   = state_q == HOLD;
    assign bus.result      = res_q;
    assign bus.zero        = zero_q;
    assign bus.alu_ctrl    = ctrl_q;
    assign bus.illegal     = ill_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule
